// File: rtl/dadd_rsp_buf_if.sv
// dadd_rsp_buf_if -- signal bundle between the dadd result stage, the response
// buffer and the downstream consumer.
//
// Modports:
//   slave  : the response buffer (consumes results, produces rsp_* and status)
//   master : the environment (dadd stage + consumer + error-clear source)
//
// Signals:
//   dadd_out_en / dadd_out_addr / dadd_out : result strobe, address tag, data
//   rsp_valid / rsp_ready                  : head-entry handshake
//   rsp_addr / rsp_data                    : head entry contents
//   rsp_count                              : occupancy, 0..DEPTH
//   ovf_err / drop_cnt                     : sticky drop flag, saturating drop count
//   clr_err                                : synchronous clear of ovf_err/drop_cnt
interface dadd_rsp_buf_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          dadd_out_en;
  logic [31:0]   dadd_out_addr;
  logic [31:0]   dadd_out;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_addr;
  logic [31:0]   rsp_data;
  logic [CW-1:0] rsp_count;
  logic          ovf_err;
  logic [7:0]    drop_cnt;
  logic          clr_err;

  modport slave (
    input  dadd_out_en, dadd_out_addr, dadd_out, rsp_ready, clr_err,
    output rsp_valid, rsp_addr, rsp_data, rsp_count, ovf_err, drop_cnt
  );

  modport master (
    output dadd_out_en, dadd_out_addr, dadd_out, rsp_ready, clr_err,
    input  rsp_valid, rsp_addr, rsp_data, rsp_count, ovf_err, drop_cnt
  );
endinterface

// File: rtl/dadd_rsp_buf.sv
// dadd_rsp_buf -- response buffer behind the dadd stage.
//
// Results arrive with no backpressure and are queued in a DEPTH-entry circular
// buffer of {addr,data} pairs. The oldest entry is presented first-word
// fall-through on rsp_*. A result arriving while the buffer is full is dropped
// unless a pop frees a slot on the same edge; drops set the sticky ovf_err and
// bump the saturating drop_cnt.
//
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dadd_rsp_buf_if.slave (result input, response output, status)
module dadd_rsp_buf #(
  parameter int DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  dadd_rsp_buf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_err;
  logic [7:0]    drop_cnt;

  logic          not_empty;
  logic          full;
  logic          pop;
  logic          push_acc;
  logic          drop;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = not_empty & bus.rsp_ready;
  // A full buffer still accepts a result when the head leaves on the same edge.
  assign push_acc  = bus.dadd_out_en & (~full | pop);
  assign drop      = bus.dadd_out_en & full & ~pop;

  // Storage is not reset; unwritten slots are never visible because the
  // outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= {bus.dadd_out_addr, bus.dadd_out};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_acc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as clr_err wins, restarting the count at 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      ovf_err <= 1'b1;
      if (bus.clr_err) begin
        drop_cnt <= 8'd1;
      end else if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end else if (bus.clr_err) begin
      ovf_err  <= 1'b0;
      drop_cnt <= '0;
    end
  end

  logic [63:0] head;
  assign head = not_empty ? mem[rd_ptr] : '0;

  assign bus.rsp_valid = not_empty;
  assign bus.rsp_addr  = head[63:32];
  assign bus.rsp_data  = head[31:0];
  assign bus.rsp_count = count;
  assign bus.ovf_err   = ovf_err;
  assign bus.drop_cnt  = drop_cnt;
endmodule
